// File: rtl/vpu_src_fetch_unit.sv
// ---------------------------------------------------------------------------
// vpu_src_fetch_unit
//
// Fetches one SRAM line for a VPU source operand and streams it to the lane
// in DWIDTH_PER_EXEC-wide beats, lowest chunk first. In scalar mode only
// chunk 0 is sent, as a single beat marked last.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   start_i           : one-cycle fetch start, accepted only while idle
//   src_addr_i        : {bank id, row} of the source line
//   scalar_i          : 1 = send chunk 0 only, 0 = send all EXEC_CNT chunks
//   done_o            : unit idle and able to accept start_i
//   sram_req_o        : SRAM read request
//   sram_rid_o        : bank id of the request (0 when no request)
//   sram_addr_o       : row address of the request (0 when no request)
//   sram_ack_i        : SRAM accepted the request
//   sram_rvalid_i     : read line valid
//   sram_rdata_i      : read line
//   lane_valid_o      : beat valid towards the lane
//   lane_ready_i      : lane accepts the beat
//   lane_data_o       : beat data (0 when no beat is offered)
//   lane_last_o       : final beat of the fetch
//   fsm_state         : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where the sender's
// valid/req and the receiver's ready/ack are both high. Once the sender
// raises valid/req it keeps it high, with payload unchanged, until that
// transfer happens. The sender never waits for ready/ack before raising
// valid/req.
// ---------------------------------------------------------------------------
module vpu_src_fetch_unit #(
    parameter int SRAM_DATA_WIDTH     = 512,
    parameter int DWIDTH_PER_EXEC     = 128,
    parameter int SRAM_BANK_CNT_LG2   = 3,
    parameter int SRAM_BANK_DEPTH_LG2 = 10
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start_i,
    input  logic [SRAM_BANK_CNT_LG2+SRAM_BANK_DEPTH_LG2-1:0] src_addr_i,
    input  logic                                         scalar_i,
    output logic                                         done_o,
    output logic                                         sram_req_o,
    output logic [SRAM_BANK_CNT_LG2-1:0]                 sram_rid_o,
    output logic [SRAM_BANK_DEPTH_LG2-1:0]               sram_addr_o,
    input  logic                                         sram_ack_i,
    input  logic                                         sram_rvalid_i,
    input  logic [SRAM_DATA_WIDTH-1:0]                   sram_rdata_i,
    output logic                                         lane_valid_o,
    input  logic                                         lane_ready_i,
    output logic [DWIDTH_PER_EXEC-1:0]                   lane_data_o,
    output logic                                         lane_last_o,
    output logic [1:0]                                   fsm_state
);

    localparam int EXEC_CNT = SRAM_DATA_WIDTH / DWIDTH_PER_EXEC;
    localparam int ADDR_W   = SRAM_BANK_CNT_LG2 + SRAM_BANK_DEPTH_LG2;
    // Keep the counter at least one bit wide even for a single-chunk line.
    localparam int CNT_W    = (EXEC_CNT > 1) ? $clog2(EXEC_CNT) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(EXEC_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT   = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Request captured at start; held unchanged until the next accepted start.
    logic [SRAM_BANK_CNT_LG2-1:0]   rid_q;
    logic [SRAM_BANK_DEPTH_LG2-1:0] row_q;
    logic                           scalar_q;

    // Line buffer and beat index into it.
    logic [SRAM_DATA_WIDTH-1:0]     line_q;
    logic [CNT_W-1:0]               cnt_q;

    // Per-cycle control strobes from the FSM.
    logic                           latch_req;
    logic                           load_line;
    logic                           beat_xfer;
    logic                           is_last;

    // The final beat is chunk 0 in scalar mode, otherwise the top chunk.
    assign is_last = scalar_q ? (cnt_q == '0) : (cnt_q == LAST_CNT);

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rid_q    <= '0;
            row_q    <= '0;
            scalar_q <= 1'b0;
            line_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;

            if (latch_req) begin
                rid_q    <= src_addr_i[ADDR_W-1 -: SRAM_BANK_CNT_LG2];
                row_q    <= src_addr_i[SRAM_BANK_DEPTH_LG2-1:0];
                scalar_q <= scalar_i;
            end

            if (load_line) begin
                line_q <= sram_rdata_i;
                cnt_q  <= '0;
            end else if (beat_xfer) begin
                // The last beat resets the index so it never wraps past
                // the top chunk.
                cnt_q <= is_last ? '0 : cnt_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and control outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        latch_req    = 1'b0;
        load_line    = 1'b0;
        beat_xfer    = 1'b0;
        done_o       = 1'b0;
        sram_req_o   = 1'b0;
        lane_valid_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                done_o = 1'b1;
                if (start_i) begin
                    latch_req = 1'b1;
                    state_d   = S_REQ;
                end
            end

            S_REQ: begin
                sram_req_o = 1'b1;
                // rvalid seen in this state (even with the ack) is not ours.
                if (sram_ack_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (sram_rvalid_i) begin
                    load_line = 1'b1;
                    state_d   = S_STREAM;
                end
            end

            S_STREAM: begin
                lane_valid_o = 1'b1;
                if (lane_ready_i) begin
                    beat_xfer = 1'b1;
                    if (is_last) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Payload outputs: zero whenever the matching valid/req is low.
    // -----------------------------------------------------------------------
    assign sram_rid_o  = (state_q == S_REQ) ? rid_q : '0;
    assign sram_addr_o = (state_q == S_REQ) ? row_q : '0;

    assign lane_data_o = (state_q == S_STREAM)
                       ? line_q[cnt_q*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC]
                       : '0;
    assign lane_last_o = (state_q == S_STREAM) && is_last;

    assign fsm_state = state_q;

endmodule

// File: doc/vpu_src_fetch_unit.md
VPU_SRC_FETCH_UNIT -- requirements
Module: vpu_src_fetch_unit

Interface
REQ-001 Parameter SRAM_DATA_WIDTH, default 512, SHALL set the SRAM read line width in bits.
REQ-002 Parameter DWIDTH_PER_EXEC, default 128, SHALL set the per-beat lane data width; EXEC_CNT = SRAM_DATA_WIDTH/DWIDTH_PER_EXEC (default 4).
REQ-003 Parameter SRAM_BANK_CNT_LG2, default 3, SHALL set the bank-id width.
REQ-004 Parameter SRAM_BANK_DEPTH_LG2, default 10, SHALL set the row-address width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start_i  input  1  one-cycle fetch start from the controller.
REQ-009 src_addr_i  input  SRAM_BANK_CNT_LG2+SRAM_BANK_DEPTH_LG2  source address; upper bits are the bank id, lower bits the row.
REQ-010 scalar_i  input  1  1 = stream chunk 0 only, as a single beat; 0 = stream all EXEC_CNT chunks.
REQ-011 done_o  output  1  unit idle and ready to accept start_i.
REQ-012 sram_req_o  output  1  SRAM read request.
REQ-013 sram_rid_o  output  SRAM_BANK_CNT_LG2  bank id of the request.
REQ-014 sram_addr_o  output  SRAM_BANK_DEPTH_LG2  row address of the request.
REQ-015 sram_ack_i  input  1  request accepted; the handshake completes when sram_req_o and sram_ack_i are both high.
REQ-016 sram_rvalid_i  input  1  read data valid.
REQ-017 sram_rdata_i  input  SRAM_DATA_WIDTH  read line.
REQ-018 lane_valid_o  output  1  beat valid to the VPU lane.
REQ-019 lane_ready_i  input  1  lane accepts the beat.
REQ-020 lane_data_o  output  DWIDTH_PER_EXEC  beat data.
REQ-021 lane_last_o  output  1  marks the final beat of a fetch.

Function
REQ-022 The FSM SHALL have four states: S_IDLE, S_REQ, S_WAIT, S_STREAM.
REQ-023 S_IDLE: done_o=1 combinationally; start_i=1 SHALL latch rid, row and scalar_i, and go to S_REQ next cycle.
REQ-024 S_REQ: sram_req_o=1 with stable rid/addr; on req&&ack go to S_WAIT and drive req=0, rid=0, addr=0 from the next cycle.
REQ-025 S_WAIT: on sram_rvalid_i, capture sram_rdata_i into a line buffer, set beat counter cnt=0, and go to S_STREAM.
REQ-026 S_STREAM: lane_valid_o=1; lane_data_o = line[cnt*DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC].
REQ-027 A beat SHALL transfer only when lane_valid_o and lane_ready_i are both high; on each transfer, cnt increments by 1.
REQ-028 While valid && !ready, lane_data_o, lane_last_o and cnt SHALL hold stable.
REQ-029 lane_last_o=1 when cnt==EXEC_CNT-1 (scalar=0), or cnt==0 (scalar=1).
REQ-030 A transfer with lane_last_o=1 SHALL return the FSM to S_IDLE next cycle; cnt resets to 0 and never wraps past EXEC_CNT-1.
REQ-031 start_i outside S_IDLE SHALL be ignored and SHALL NOT alter latched state.
REQ-032 sram_ack_i outside S_REQ and sram_rvalid_i outside S_WAIT SHALL be ignored.
REQ-033 sram_rvalid_i in the same cycle as the ack SHALL be ignored; read data is accepted only in S_WAIT.
REQ-034 Minimum fetch latency: start_i at cycle T -> req at T+1 -> (ack at T+1, rvalid at T+2) -> first beat valid at T+3.
REQ-035 lane_valid_o SHALL be 0 in every state other than S_STREAM; lane_data_o is then 0.

Reset
REQ-036 With rst=1 at a clock edge, the next state SHALL be: S_IDLE, done_o=1, sram_req_o=0, sram_rid_o=0, sram_addr_o=0, lane_valid_o=0, lane_last_o=0, lane_data_o=0, cnt=0, line buffer=0.
REQ-037 Reset mid-operation SHALL abandon the fetch at that edge with no further req or beat; a later rvalid is ignored.

Verification
REQ-038 Basic fetch: src_addr_i=0x1A5, scalar=0, ack the same cycle, rvalid 2 cycles later, ready=1 -> rid=0, addr=0x1A5; 4 beats = line[127:0], [255:128], [383:256], [511:384]; last on beat 4; done_o=1 the following cycle.
REQ-039 Backpressure: lane_ready_i low for 3 cycles on beat 2 -> beat-2 data and cnt held for those 3 cycles; total of exactly 4 transfers.
REQ-040 Delayed ack: ack withheld for 5 cycles -> sram_req_o high for 6 cycles with stable rid/addr; req deasserts the cycle after ack.
REQ-041 Scalar mode: scalar_i=1 -> exactly one beat of line[127:0] with lane_last_o=1, then S_IDLE.
REQ-042 start_i pulsed in S_STREAM with a different address -> ignored; the in-flight beats are unchanged and no second req is issued.
REQ-043 rst asserted in S_WAIT, then rvalid pulsed -> all outputs at reset values, done_o=1, no lane beats.
